// File: rtl/debug_ocimem_arbiter.sv
// debug_ocimem_arbiter
// Shares the single-port Nios II OCI debug RAM (1-cycle read latency) between
// the JTAG debug host and the CPU's Avalon debug-slave port. It keeps the
// auto-incrementing monitor address, arbitrates each RAM cycle round-robin,
// and returns read data plus ready/error status to the debug-slave wrapper.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   jtag_addr_load/addr     load the monitor address
//   jtag_wr_strobe/wdata    write at mon_areg, then increment
//   jtag_rd_strobe          read mon_areg into mon_dreg, then increment
//   mon_dreg, mon_areg      monitor data / address registers
//   mon_ready               one-cycle pulse after each JTAG access completes
//   mon_error               sticky protocol error, cleared by an accepted address load
//   cpu_*                   Avalon slave (read, write, waitrequest, data)
//   ram_*                   single-port RAM address, write enable, write/read data
module debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_wr_strobe,
  input  logic              jtag_rd_strobe,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] mon_dreg,
  output logic [ADDR_W-1:0] mon_areg,
  output logic              mon_ready,
  output logic              mon_error,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD_CPU, RD_JTAG} state_t;
  typedef enum logic {GRANT_CPU, GRANT_JTAG} grant_t;

  state_t            state, state_next;
  grant_t            last_grant;
  logic              jtag_pend;
  logic              jtag_pend_wr;
  logic [DATA_W-1:0] jtag_pend_wdata;
  logic [ADDR_W-1:0] ram_addr_q;

  logic cpu_req;
  logic grant_cpu, grant_jtag;
  logic cpu_wr_grant, jtag_wr_grant;
  logic jtag_done;
  logic strobe_any, strobe_multi, strobe_ok;

  assign cpu_req = cpu_read | cpu_write;

  // A strobe is usable only if it is alone and nothing is pending. The
  // pending flag is still set in the completion cycle, so a strobe landing
  // there counts as a collision.
  assign strobe_any   = jtag_addr_load | jtag_wr_strobe | jtag_rd_strobe;
  assign strobe_multi = (jtag_addr_load & jtag_wr_strobe) |
                        (jtag_addr_load & jtag_rd_strobe) |
                        (jtag_wr_strobe & jtag_rd_strobe);
  assign strobe_ok    = strobe_any & ~strobe_multi & ~jtag_pend;

  // Arbitration: grants are only made from IDLE; on a conflict the requester
  // that did not win last time gets the RAM.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    grant_cpu  = 1'b0;
    grant_jtag = 1'b0;
    if (state == IDLE) begin
      if (cpu_req && jtag_pend) begin
        grant_cpu  = (last_grant == GRANT_JTAG);
        grant_jtag = (last_grant == GRANT_CPU);
      end else begin
        grant_cpu  = cpu_req;
        grant_jtag = jtag_pend;
      end
    end
  end

  assign cpu_wr_grant  = grant_cpu & cpu_write;
  assign jtag_wr_grant = grant_jtag & jtag_pend_wr;
  assign jtag_done     = jtag_wr_grant | (state == RD_JTAG);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_cpu && !cpu_write)         state_next = RD_CPU;
        else if (grant_jtag && !jtag_pend_wr) state_next = RD_JTAG;
      end
      RD_CPU:  state_next = IDLE;
      RD_JTAG: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: RAM port, CPU read data and waitrequest
  always_comb begin
    ram_addr  = ram_addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    cpu_rdata = '0;
    if (grant_cpu) begin
      ram_addr = cpu_addr;
      if (cpu_write) begin
        ram_we    = 1'b1;
        ram_wdata = cpu_wdata;
      end
    end else if (grant_jtag) begin
      ram_addr = mon_areg;
      if (jtag_pend_wr) begin
        ram_we    = 1'b1;
        ram_wdata = jtag_pend_wdata;
      end
    end
    if (state == RD_CPU) cpu_rdata = ram_rdata;
    cpu_waitrequest = cpu_req & ~(cpu_wr_grant | (state == RD_CPU));
  end

  // Grant history and held RAM address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GRANT_JTAG;
      ram_addr_q <= '0;
    end else if (grant_cpu) begin
      last_grant <= GRANT_CPU;
      ram_addr_q <= cpu_addr;
    end else if (grant_jtag) begin
      last_grant <= GRANT_JTAG;
      ram_addr_q <= mon_areg;
    end
  end

  // JTAG pending operation. Set and clear are exclusive: a strobe is only
  // accepted with nothing pending, and completion requires a pending op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_pend       <= 1'b0;
      jtag_pend_wr    <= 1'b0;
      jtag_pend_wdata <= '0;
    end else if (jtag_done) begin
      jtag_pend <= 1'b0;
    end else if (strobe_ok && !jtag_addr_load) begin
      jtag_pend       <= 1'b1;
      jtag_pend_wr    <= jtag_wr_strobe;
      jtag_pend_wdata <= jtag_wdata;
    end
  end

  // Monitor registers seen by the JTAG scan chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_areg  <= '0;
      mon_dreg  <= '0;
      mon_ready <= 1'b0;
      mon_error <= 1'b0;
    end else begin
      mon_ready <= jtag_done;
      if (state == RD_JTAG) mon_dreg <= ram_rdata;
      // Increment wraps modulo 2^ADDR_W; a load cannot coincide with it
      // because loads are refused while an access is pending.
      if (jtag_done)                          mon_areg <= mon_areg + ADDR_W'(1);
      else if (strobe_ok && jtag_addr_load)   mon_areg <= jtag_addr;
      if (strobe_any && !strobe_ok)           mon_error <= 1'b1;
      else if (strobe_ok && jtag_addr_load)   mon_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Self-checking bench for debug_ocimem_arbiter. A behavioural RAM is attached
// to the RAM port; exp_mem is the reference image of what the RAM must hold,
// updated only from the access rules (writes land, reads return the image).
module tb_debug_ocimem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              jtag_addr_load, jtag_wr_strobe, jtag_rd_strobe;
  logic [ADDR_W-1:0] jtag_addr;
  logic [DATA_W-1:0] jtag_wdata;
  logic [DATA_W-1:0] mon_dreg;
  logic [ADDR_W-1:0] mon_areg;
  logic              mon_ready, mon_error;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_read, cpu_write;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic [DATA_W-1:0] exp_dreg;
  bit                ram_init = 1'b1;
  int                tests_run = 0;
  int                tests_failed = 0;

  always #5 clk = ~clk;

  debug_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr),
    .jtag_wr_strobe(jtag_wr_strobe), .jtag_rd_strobe(jtag_rd_strobe),
    .jtag_wdata(jtag_wdata), .mon_dreg(mon_dreg), .mon_areg(mon_areg),
    .mon_ready(mon_ready), .mon_error(mon_error),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM, registered read
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= exp_mem[i];
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    jtag_addr_load = 1'b0; jtag_wr_strobe = 1'b0; jtag_rd_strobe = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  // One-cycle address load; called at a negedge, returns at the next negedge.
  task automatic jtag_load(input logic [ADDR_W-1:0] a);
    jtag_addr = a; jtag_addr_load = 1'b1;
    @(negedge clk);
    jtag_addr_load = 1'b0;
  endtask

  // Strobe in cycle 0, then observe cycles 1..window.
  task automatic jtag_access(input bit wr, input logic [DATA_W-1:0] d, input int window,
                             output int ready_at, output int ready_cnt,
                             output logic [DATA_W-1:0] dreg_at_ready,
                             output int we_at, output logic [ADDR_W-1:0] we_addr);
    ready_at = -1; ready_cnt = 0; dreg_at_ready = '0; we_at = -1; we_addr = '0;
    jtag_wdata = d;
    if (wr) jtag_wr_strobe = 1'b1; else jtag_rd_strobe = 1'b1;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      jtag_wr_strobe = 1'b0; jtag_rd_strobe = 1'b0;
      #1;
      if (ram_we === 1'b1 && we_at < 0) begin we_at = c; we_addr = ram_addr; end
      if (mon_ready === 1'b1) begin
        ready_cnt++;
        if (ready_at < 0) begin ready_at = c; dreg_at_ready = mon_dreg; end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    reset_n = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if ({mon_dreg, mon_areg, mon_ready, mon_error} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mon: dreg=%h areg=%h rdy=%b err=%b, required all zero",
               mon_dreg, mon_areg, mon_ready, mon_error);
    end
    tests_run++;
    if ({ram_we, ram_addr, cpu_rdata, cpu_waitrequest} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: we=%b addr=%h rdata=%h wait=%b, required all zero",
               ram_we, ram_addr, cpu_rdata, cpu_waitrequest);
    end
  endtask

  task automatic test_jtag_write();
    int ra, rc, wa; logic [DATA_W-1:0] dr; logic [ADDR_W-1:0] wadr;
    @(negedge clk);
    jtag_load(8'h10);
    #1;
    tests_run++;
    if (mon_areg !== 8'h10) begin
      tests_failed++; $display("FAIL addr_load: areg=%h required 10", mon_areg);
    end
    jtag_access(1'b1, 32'hDEADBEEF, 5, ra, rc, dr, wa, wadr);
    exp_mem[8'h10] = 32'hDEADBEEF;
    tests_run++;
    if (wa !== 1 || wadr !== 8'h10) begin
      tests_failed++; $display("FAIL jwr_ram_cycle: cycle=%0d addr=%h required 1/10", wa, wadr);
    end
    tests_run++;
    if (ra !== 2 || rc !== 1) begin
      tests_failed++; $display("FAIL jwr_ready: at=%0d count=%0d required 2/1", ra, rc);
    end
    tests_run++;
    if (ram[8'h10] !== 32'hDEADBEEF || mon_areg !== 8'h11) begin
      tests_failed++;
      $display("FAIL jwr_result: ram=%h areg=%h required deadbeef/11", ram[8'h10], mon_areg);
    end
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    cpu_addr = 8'h10; cpu_read = 1'b1;
    #1;
    tests_run++;
    if (cpu_waitrequest !== 1'b1) begin
      tests_failed++; $display("FAIL cpu_rd_wait1: wait=%b required 1", cpu_waitrequest);
    end
    @(negedge clk); #1;
    tests_run++;
    if (cpu_waitrequest !== 1'b0 || cpu_rdata !== exp_mem[8'h10]) begin
      tests_failed++;
      $display("FAIL cpu_rd_data: wait=%b rdata=%h required 0/%h",
               cpu_waitrequest, cpu_rdata, exp_mem[8'h10]);
    end
    @(negedge clk);
    cpu_read = 1'b0;
  endtask

  task automatic test_jtag_read();
    int ra, rc, wa; logic [DATA_W-1:0] dr; logic [ADDR_W-1:0] wadr;
    @(negedge clk);
    jtag_load(8'h10);
    jtag_access(1'b0, '0, 5, ra, rc, dr, wa, wadr);
    exp_dreg = exp_mem[8'h10];
    tests_run++;
    if (ra !== 3 || rc !== 1 || dr !== exp_dreg) begin
      tests_failed++;
      $display("FAIL jrd_latency: at=%0d count=%0d dreg=%h required 3/1/%h", ra, rc, dr, exp_dreg);
    end
    tests_run++;
    if (wa !== -1 || mon_areg !== 8'h11) begin
      tests_failed++; $display("FAIL jrd_side: we_at=%0d areg=%h required -1/11", wa, mon_areg);
    end
  endtask

  // Continuous CPU reads with a JTAG read striking in two different phases.
  task automatic test_contention();
    logic [ADDR_W-1:0] a, b; int s, ready_c, cpu_done, cpu_bad, cpu_after;
    for (int phase = 0; phase < 2; phase++) begin
      @(negedge clk);
      a = ADDR_W'(8'h20 + phase); b = ADDR_W'(8'h30 + phase);
      s = 2 + phase; ready_c = -1; cpu_done = 0; cpu_bad = 0; cpu_after = 0;
      jtag_load(b);
      cpu_addr = a; cpu_read = 1'b1;
      for (int c = 0; c < 14; c++) begin
        jtag_rd_strobe = (c == s);
        #1;
        if (cpu_waitrequest === 1'b0) begin
          cpu_done++;
          if (ready_c >= 0) cpu_after++;
          if (cpu_rdata !== exp_mem[a]) cpu_bad++;
        end
        if (mon_ready === 1'b1 && ready_c < 0) ready_c = c;
        @(negedge clk);
      end
      cpu_read = 1'b0; jtag_rd_strobe = 1'b0;
      exp_dreg = exp_mem[b];
      tests_run++;
      if (ready_c < s + 3 || ready_c > s + 4) begin
        tests_failed++;
        $display("FAIL contend_latency[%0d]: ready %0d cycles after strobe, required 3..4",
                 phase, ready_c - s);
      end
      tests_run++;
      if (mon_dreg !== exp_dreg) begin
        tests_failed++; $display("FAIL contend_dreg[%0d]: %h required %h", phase, mon_dreg, exp_dreg);
      end
      tests_run++;
      if (cpu_bad !== 0 || cpu_done < 5 || cpu_after < 1) begin
        tests_failed++;
        $display("FAIL contend_cpu[%0d]: bad=%0d done=%0d after_jtag=%0d required 0/>=5/>=1",
                 phase, cpu_bad, cpu_done, cpu_after);
      end
    end
  endtask

  task automatic test_wrap();
    int ra, rc, wa; logic [DATA_W-1:0] dr, d; logic [ADDR_W-1:0] wadr;
    @(negedge clk);
    d = $urandom;
    jtag_load(8'hFF);
    jtag_access(1'b1, d, 5, ra, rc, dr, wa, wadr);
    exp_mem[8'hFF] = d;
    tests_run++;
    if (wadr !== 8'hFF || ram[8'hFF] !== d || mon_areg !== 8'h00 || rc !== 1) begin
      tests_failed++;
      $display("FAIL wrap_write: addr=%h ram=%h areg=%h rdy=%0d required ff/%h/00/1",
               wadr, ram[8'hFF], mon_areg, rc, d);
    end
    jtag_access(1'b0, '0, 5, ra, rc, dr, wa, wadr);
    exp_dreg = exp_mem[8'h00];
    tests_run++;
    if (dr !== exp_dreg || mon_areg !== 8'h01) begin
      tests_failed++;
      $display("FAIL wrap_read: dreg=%h areg=%h required %h/01", dr, mon_areg, exp_dreg);
    end
  endtask

  // Read strobe, then a write strobe one cycle later while the read is pending.
  task automatic test_collision();
    logic [ADDR_W-1:0] a; int rc; bit we_seen; logic [DATA_W-1:0] dr;
    @(negedge clk);
    a = ADDR_W'(8'h40 + $urandom_range(0, 15));
    jtag_load(a);
    rc = 0; we_seen = 1'b0; dr = '0;
    for (int c = 0; c < 8; c++) begin
      jtag_rd_strobe = (c == 0); jtag_wr_strobe = (c == 1); jtag_wdata = 32'h1234_5678;
      #1;
      if (ram_we === 1'b1) we_seen = 1'b1;
      if (mon_ready === 1'b1) begin rc++; dr = mon_dreg; end
      @(negedge clk);
    end
    exp_dreg = exp_mem[a];
    tests_run++;
    if (mon_error !== 1'b1 || rc !== 1 || we_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL collide_status: err=%b ready=%0d we_seen=%b required 1/1/0", mon_error, rc, we_seen);
    end
    tests_run++;
    if (dr !== exp_dreg || mon_areg !== a + ADDR_W'(1)) begin
      tests_failed++;
      $display("FAIL collide_read: dreg=%h areg=%h required %h/%h", dr, mon_areg, exp_dreg, a + ADDR_W'(1));
    end
    jtag_load(8'h00);
    #1;
    tests_run++;
    if (mon_error !== 1'b0) begin
      tests_failed++; $display("FAIL error_clear: err=%b required 0", mon_error);
    end
  endtask

  // Read strobe arriving in the completion cycle of a JTAG write.
  task automatic test_completion_collision();
    logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; int rc;
    @(negedge clk);
    a = ADDR_W'(8'h50 + $urandom_range(0, 15)); d = $urandom; rc = 0;
    jtag_load(a);
    for (int c = 0; c < 7; c++) begin
      jtag_wr_strobe = (c == 0); jtag_rd_strobe = (c == 1); jtag_wdata = d;
      #1;
      if (mon_ready === 1'b1) rc++;
      @(negedge clk);
    end
    exp_mem[a] = d;
    tests_run++;
    if (mon_error !== 1'b1 || rc !== 1 || ram[a] !== d) begin
      tests_failed++;
      $display("FAIL done_collide: err=%b ready=%0d ram=%h required 1/1/%h", mon_error, rc, ram[a], d);
    end
    tests_run++;
    if (mon_dreg !== exp_dreg || mon_areg !== a + ADDR_W'(1)) begin
      tests_failed++;
      $display("FAIL done_collide_regs: dreg=%h areg=%h required %h/%h",
               mon_dreg, mon_areg, exp_dreg, a + ADDR_W'(1));
    end
  endtask

  // Two strobes in the same cycle: both ignored, error flagged.
  task automatic test_multi_strobe();
    int rc; bit we_seen;
    @(negedge clk);
    jtag_load(8'h60);
    rc = 0; we_seen = 1'b0;
    jtag_addr = 8'h77; jtag_addr_load = 1'b1; jtag_rd_strobe = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      jtag_addr_load = 1'b0; jtag_rd_strobe = 1'b0;
      #1;
      if (mon_ready === 1'b1) rc++;
      if (ram_we === 1'b1) we_seen = 1'b1;
    end
    tests_run++;
    if (mon_error !== 1'b1 || mon_areg !== 8'h60 || rc !== 0 || we_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL multi_strobe: err=%b areg=%h ready=%0d we=%b required 1/60/0/0",
               mon_error, mon_areg, rc, we_seen);
    end
    jtag_load(8'h00);
    #1;
    tests_run++;
    if (mon_error !== 1'b0) begin
      tests_failed++; $display("FAIL multi_clear: err=%b required 0", mon_error);
    end
  endtask

  // CPU traffic on the upper half of the RAM, concurrent with JTAG traffic on
  // the lower quarter.
  task automatic cpu_random();
    logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; bit wr, done;
    for (int i = 0; i < 40; i++) begin
      a = ADDR_W'(8'h80 + $urandom_range(0, 127)); d = $urandom; wr = 1'($urandom_range(0, 1));
      cpu_addr = a; cpu_wdata = d; cpu_write = wr; cpu_read = ~wr;
      done = 1'b0;
      for (int w = 0; w < 8 && !done; w++) begin
        #1;
        if (cpu_waitrequest === 1'b0) begin
          done = 1'b1;
          if (wr) exp_mem[a] = d;
          else begin
            tests_run++;
            if (cpu_rdata !== exp_mem[a]) begin
              tests_failed++;
              $display("FAIL rand_cpu_rd: addr=%h rdata=%h required %h", a, cpu_rdata, exp_mem[a]);
            end
          end
        end
        @(negedge clk);
      end
      cpu_read = 1'b0; cpu_write = 1'b0;
      if (!done) begin
        tests_run++; tests_failed++;
        $display("FAIL rand_cpu_timeout: addr=%h waitrequest never dropped", a);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic jtag_random();
    logic [ADDR_W-1:0] a, wadr; logic [DATA_W-1:0] d, dr; bit wr; int ra, rc, wa, lo;
    for (int i = 0; i < 15; i++) begin
      a = ADDR_W'($urandom_range(0, 62)); d = $urandom; wr = 1'($urandom_range(0, 1));
      jtag_load(a);
      jtag_access(wr, d, 7, ra, rc, dr, wa, wadr);
      lo = wr ? 2 : 3;
      tests_run++;
      if (rc !== 1 || ra < lo || ra > lo + 2) begin
        tests_failed++;
        $display("FAIL rand_jtag_ready: wr=%b at=%0d count=%0d required %0d..%0d/1", wr, ra, rc, lo, lo + 2);
      end
      if (wr) exp_mem[a] = d;
      else begin
        tests_run++;
        if (dr !== exp_mem[a]) begin
          tests_failed++; $display("FAIL rand_jtag_rd: addr=%h dreg=%h required %h", a, dr, exp_mem[a]);
        end
      end
      tests_run++;
      if (mon_areg !== a + ADDR_W'(1)) begin
        tests_failed++; $display("FAIL rand_jtag_areg: %h required %h", mon_areg, a + ADDR_W'(1));
      end
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    fork
      cpu_random();
      jtag_random();
    join
    @(negedge clk);
    tests_run++;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== exp_mem[i]) begin
        tests_failed++;
        $display("FAIL rand_ram_image: addr=%0h ram=%h required %h", i, ram[i], exp_mem[i]);
        break;
      end
    end
  endtask

  // Reset asserted while a JTAG read is in RD_JTAG.
  task automatic test_reset_mid_op();
    int rc; bit bad_dreg;
    @(negedge clk);
    jtag_load(8'h10);
    jtag_rd_strobe = 1'b1;
    @(negedge clk); jtag_rd_strobe = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({mon_dreg, mon_areg, mon_ready, mon_error, ram_we, ram_addr, cpu_rdata, cpu_waitrequest} !== '0) begin
      tests_failed++;
      $display("FAIL midop_reset: dreg=%h areg=%h rdy=%b err=%b we=%b addr=%h required all zero",
               mon_dreg, mon_areg, mon_ready, mon_error, ram_we, ram_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rc = 0; bad_dreg = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (mon_ready === 1'b1) rc++;
      if (mon_dreg !== '0) bad_dreg = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (rc !== 0 || bad_dreg !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_after: ready=%0d dreg_nonzero=%b required 0/0", rc, bad_dreg);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    jtag_addr = '0; jtag_wdata = '0; cpu_addr = '0; cpu_wdata = '0;
    exp_dreg = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = $urandom;
    test_reset();
    test_jtag_write();
    test_cpu_read();
    test_jtag_read();
    test_contention();
    test_wrap();
    test_collision();
    test_completion_collision();
    test_multi_strobe();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
